io_clk_divider_bank: RTL
========================

Name: io_clk_divider_bank

Overview:
Multi-channel, single-clock successor to the per-cell IO clock generator. It derives CHANNELS independent divided clocks and strobes from sys_clk, so no clock-domain crossing is needed. Each channel is configured through the shared ACK/REQ config port used by the IO cells. New settings are staged and applied only at a period boundary, which keeps every output glitch-free. Sits in the IO subsystem beside the IO cells, feeding their bit-clock and sample-strobe inputs.

Parameters:
DATABITWIDTH, 16, width of ResponseDataOut; config word is zero-extended into it
CHANNELS, 4, number of independent divider channels (1..16)
DIVBITS, 14, divisor/counter width (1..14); config bits [13:DIVBITS] are ignored and read back as 0

Ports:
sys_clk  input  1  sole clock
sync_rst  input  1  synchronous active-high reset
clk_en  input  1  global clock enable; low freezes all state
ConfigACK  input  1  requester valid (write or read)
ConfigREQ  output  1  block ready
LoadEn  input  1  1 = read-back request, 0 = config write
ConfigWordIn  input  16  [13:0] divisor D, [14] mode (0 square, 1 strobe), [15] channel enable
ConfigChanIn  input  4  target channel index
ConfigRegDestIn  input  4  register tag echoed on the response
ResponseACK  output  1  response valid
ResponseREQ  input  1  response consumer ready
ResponseRegDestOut  output  4  equals ConfigRegDestIn
ResponseDataOut  output  DATABITWIDTH  zero-extended active config of the target channel
divided_clk  output  CHANNELS  per-channel square output
divided_strobe  output  CHANNELS  per-channel single-cycle strobe
ChannelPending  output  CHANNELS  staged config not yet applied

Behaviour:
- Reset: sync_rst has top priority, including over clk_en. On reset, all active and pending configs go to 0, all counters go to 0, and divided_clk, divided_strobe and ChannelPending are all 0.
- Handshake, write path (LoadEn=0):
  - ConfigREQ = clk_en && ~ChannelPending[ConfigChanIn].
  - A write is accepted when ConfigACK && ConfigREQ. The word is latched into the channel's pending register and ChannelPending is set on the next edge.
- Handshake, read path (LoadEn=1):
  - ConfigREQ = ResponseREQ and ResponseACK = ConfigACK && LoadEn, both combinational.
  - ResponseDataOut = {0, active config with bits [13:DIVBITS] cleared}. Pending contents are not visible on read-back.
- Out-of-range channel (ConfigChanIn >= CHANNELS): a write is accepted and dropped; a read returns 0.
- Per-channel counter (DIVBITS wide), when enabled and clk_en=1:
  - Terminal condition T: counter == D.
  - On T the counter goes to 0; otherwise it increments by 1.
  - Disabled channel: counter held at 0, divided_clk=0, divided_strobe=0.
- Mode 0 (square): divided_clk toggles on each T, giving a period of 2*(D+1) sys_clk cycles. divided_strobe stays 0.
- Mode 1 (strobe): divided_strobe is registered high for exactly one cycle after each T, i.e. once every D+1 cycles. divided_clk stays 0.
- D=0: mode 0 toggles every cycle (sys_clk/2); mode 1 holds divided_strobe high continuously.
- Config apply, channel enabled and pending set: the new config applies on the T edge.
  - Output update and new-config load happen on the same edge: in mode 0 divided_clk toggles; in mode 1 divided_strobe is registered high for one cycle.
  - The counter goes to 0, the active config is loaded from pending, and ChannelPending clears.
  - If the new enable=0 or the new mode=1, divided_clk is forced to 0 on that edge instead of toggling.
  - If the new mode=0, divided_strobe is 0 from that edge on.
- Config apply, channel disabled and pending set: the pending config applies on the next clk_en edge. The counter starts at 0 and divided_clk starts at 0.
- Write accepted on the same cycle as that channel's T: the write only stages. It applies at the following T.
- clk_en=0: counters, outputs and pending state are held, and no write is accepted. A read may still complete if ResponseREQ=1.
- Channels are fully independent; different channels may be written on consecutive cycles.

Test Plan:
1. Reset then idle → all outputs 0; ConfigREQ=1 when LoadEn=0 and clk_en=1; read of ch0 returns 0x0000.
2. Write ch1 = 0x8003 (enabled, square, D=3) → ChannelPending[1] pulses for 1 cycle, then divided_clk[1] runs at period 8 with 50% duty starting low; read of ch1 returns 0x8003.
3. Write ch2 = 0xC004 (strobe, D=4) → divided_strobe[2] is high 1 cycle in every 5; divided_clk[2]=0.
4. ch1 running with D=3; write ch1 = 0x8001 mid-period → old period completes; switch happens at T; new period 4; ChannelPending[1] is high and ConfigREQ is low for ch1 until the apply; no output pulse shorter than 2 cycles.
5. Drop clk_en for 10 cycles mid-period → counter and outputs are frozen and resume exactly; a write attempted during the freeze is not accepted.
6. Assert sync_rst with clk_en=0 while ch0 has a pending write → everything clears to 0; read of ch0 returns 0; a write to ch5 with CHANNELS=4 is accepted with no effect.

Source files
------------

// File: rtl/io_clk_divider_bank.sv
// Bank of independent single-clock dividers with an ACK/REQ config port.
// Staged configs take effect only at a period boundary so every output stays glitch-free.
module io_clk_divider_bank #(
    parameter int DATABITWIDTH = 16,
    parameter int CHANNELS     = 4,
    parameter int DIVBITS      = 14
) (
    input  logic                    sys_clk,
    input  logic                    sync_rst,
    input  logic                    clk_en,
    input  logic                    ConfigACK,
    output logic                    ConfigREQ,
    input  logic                    LoadEn,
    input  logic [15:0]             ConfigWordIn,
    input  logic [3:0]              ConfigChanIn,
    input  logic [3:0]              ConfigRegDestIn,
    output logic                    ResponseACK,
    input  logic                    ResponseREQ,
    output logic [3:0]              ResponseRegDestOut,
    output logic [DATABITWIDTH-1:0] ResponseDataOut,
    output logic [CHANNELS-1:0]     divided_clk,
    output logic [CHANNELS-1:0]     divided_strobe,
    output logic [CHANNELS-1:0]     ChannelPending
);

    // Enable and mode bits survive; divisor bits above DIVBITS are stored as 0.
    localparam logic [15:0] CFG_MASK = 16'hC000 | 16'((32'd1 << DIVBITS) - 32'd1);

    logic [CHANNELS-1:0][15:0] w_active_all;
    logic [CHANNELS-1:0]       w_pending;
    logic [CHANNELS-1:0]       w_clk_all;
    logic [CHANNELS-1:0]       w_stb_all;
    logic [CHANNELS-1:0]       w_sel;
    logic                      w_chan_pending;
    logic                      w_wr_accept;
    logic [15:0]               w_rd_cfg;

    // Out-of-range channel indices match nothing: reads give 0, writes land nowhere.
    always_comb begin
        w_sel          = '0;
        w_chan_pending = 1'b0;
        w_rd_cfg       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ConfigChanIn == 4'(i)) begin
                w_sel[i]       = 1'b1;
                w_chan_pending = w_pending[i];
                w_rd_cfg       = w_active_all[i];
            end
        end
    end

    assign w_wr_accept        = ConfigACK && !LoadEn && clk_en && !w_chan_pending;
    assign ConfigREQ          = LoadEn ? ResponseREQ : (clk_en && !w_chan_pending);
    assign ResponseACK        = ConfigACK && LoadEn;
    assign ResponseRegDestOut = ConfigRegDestIn;
    assign ResponseDataOut    = DATABITWIDTH'(w_rd_cfg);

    assign ChannelPending = w_pending;
    assign divided_clk    = w_clk_all;
    assign divided_strobe = w_stb_all;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [15:0]        r_active_cfg;
        logic [15:0]        r_pending_cfg;
        logic [DIVBITS-1:0] r_cnt;
        logic               r_pend;
        logic               r_clk;
        logic               r_stb;

        logic               w_term;
        logic [15:0]        w_act_nxt;
        logic [15:0]        w_pcfg_nxt;
        logic [DIVBITS-1:0] w_cnt_nxt;
        logic               w_pend_nxt;
        logic               w_clk_nxt;
        logic               w_stb_nxt;

        assign w_term = (r_cnt == r_active_cfg[DIVBITS-1:0]);

        always_comb begin
            w_act_nxt  = r_active_cfg;
            w_pcfg_nxt = r_pending_cfg;
            w_pend_nxt = r_pend;
            w_cnt_nxt  = r_cnt;
            w_clk_nxt  = r_clk;
            w_stb_nxt  = 1'b0;
            if (!r_active_cfg[15]) begin
                // Idle channel: a staged config starts cleanly from count 0, output low.
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
                if (r_pend) begin
                    w_act_nxt  = r_pending_cfg;
                    w_pend_nxt = 1'b0;
                end
            end else if (w_term) begin
                w_cnt_nxt = '0;
                w_clk_nxt = !r_active_cfg[14] && !r_clk;
                w_stb_nxt = r_active_cfg[14];
                if (r_pend) begin
                    w_act_nxt  = r_pending_cfg;
                    w_pend_nxt = 1'b0;
                    if (!r_pending_cfg[15] || r_pending_cfg[14]) begin
                        w_clk_nxt = 1'b0;
                    end
                    if (!r_pending_cfg[15] || !r_pending_cfg[14]) begin
                        w_stb_nxt = 1'b0;
                    end
                end
            end else begin
                w_cnt_nxt = r_cnt + DIVBITS'(1);
            end
            // A write is only accepted with nothing pending, so it never races an apply.
            if (w_wr_accept && w_sel[g]) begin
                w_pcfg_nxt = ConfigWordIn & CFG_MASK;
                w_pend_nxt = 1'b1;
            end
        end

        always_ff @(posedge sys_clk) begin
            if (sync_rst) begin
                r_active_cfg  <= '0;
                r_pending_cfg <= '0;
                r_cnt         <= '0;
                r_pend        <= 1'b0;
                r_clk         <= 1'b0;
                r_stb         <= 1'b0;
            end else if (clk_en) begin
                r_active_cfg  <= w_act_nxt;
                r_pending_cfg <= w_pcfg_nxt;
                r_cnt         <= w_cnt_nxt;
                r_pend        <= w_pend_nxt;
                r_clk         <= w_clk_nxt;
                r_stb         <= w_stb_nxt;
            end
        end

        assign w_active_all[g] = r_active_cfg;
        assign w_pending[g]    = r_pend;
        assign w_clk_all[g]    = r_clk;
        assign w_stb_all[g]    = r_stb;
    end

endmodule
